result_output_stage: RTL and testbench
======================================

// Module: result_output_stage
// PURPOSE
//  Registered output stage directly downstream of the combinational shift unit.
//  Captures {result, error} beats over a valid/ready handshake into a 2-entry FIFO.
//  Derives status flags per beat and keeps a saturating count of errored beats.
//  Gives the synchronous arithmetic unit a clean, registered result interface.
// PARAMETERS
//  BITS    32  width of result datapath (matches shift unit operand width)
//  CNT_W   8   width of the errored-beat counter
// PORTS
//  i_clk        in   1        clock, all state updates on rising edge
//  i_rst_n      in   1        asynchronous active-low reset
//  i_valid      in   1        upstream beat valid
//  o_ready      out  1        stage can accept a beat this cycle
//  i_result     in   BITS     signed result from shift unit
//  i_error      in   1        error flag from shift unit (result undefined when 1)
//  o_valid      out  1        head beat valid
//  i_ready      in   1        downstream accepts head beat this cycle
//  o_result     out  BITS     signed head result
//  o_flags      out  4        {err, neg, zero, ones} of head beat
//  i_clr_err    in   1        synchronous clear of error counter
//  o_err_count  out  CNT_W    number of accepted beats with i_error=1, saturating
// BEHAVIOUR
//  Reset (async, i_rst_n=0): FIFO emptied, o_valid=0, o_result=0, o_flags=0,
//   o_err_count=0, o_ready=1 (after release). Reset mid-transfer drops all beats.
//  Push = i_valid & o_ready; pop = o_valid & i_ready; o_ready = (count<2).
//  Storage: 2 entries, wr/rd pointers 1 bit each, count 0..2; pointers wrap 1->0.
//  Latency: beat pushed into empty FIFO appears on o_valid/o_result next cycle.
//  No combinational path i_valid->o_valid or i_ready->o_ready (o_ready from count).
//  Push+pop same cycle: count=1 -> stays 1, head advances to the new beat;
//   count=2 -> impossible to push (o_ready=0), pop only; count=0 -> push only.
//  Stored value per beat, computed at push time:
//   i_error=1 -> result stored as 0, flags = 4'b1000 (err only; x never stored).
//   i_error=0 -> result = i_result; err=0; neg=i_result[BITS-1];
//    zero=(i_result==0); ones=(i_result=='1). neg and ones both 1 for -1.
//  o_result/o_flags hold head entry while o_valid=1; must stay stable until pop.
//  When empty: o_valid=0, o_result=0, o_flags=0.
//  Error counter: +1 on each push with i_error=1; saturates at 2^CNT_W-1.
//   i_clr_err=1 -> counter 0 next cycle; clear wins over simultaneous increment.
//  i_valid with o_ready=0: beat not taken; upstream holds it (no counting).
// TESTING
//  1 push A=0x00000010 err=0, i_ready=1 -> next cycle o_valid=1,
//    o_result=0x10, o_flags=4'b0000; following cycle o_valid=0.
//  2 i_ready=0, push 3 beats (-1, 0, 5) -> o_ready=0 after 2nd; 3rd held;
//    release i_ready -> outputs -1 flags 4'b0101, then 0 flags 4'b0010, then 5.
//  3 count=1, push+pop each cycle for 20 cycles -> count stays 1, in-order
//    data, no loss/dup across pointer wrap.
//  4 CNT_W=2, push 5 beats with i_error=1 -> o_err_count 1,2,3,3,3; each beat
//    o_result=0, o_flags=4'b1000; i_clr_err with error push same cycle -> 0.
//  5 assert i_rst_n=0 asynchronously mid-cycle with 2 beats queued ->
//    o_valid=0, o_result=0, o_err_count=0 immediately; o_ready=1 after release.

Source files
------------

// File: rtl/result_output_stage.sv
// rtl/result_output_stage.sv - registered 2-entry result/flag FIFO with saturating error count
module result_output_stage #(
    parameter int BITS  = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BITS-1:0]  i_result,
    input  logic             i_error,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_result,
    output logic [3:0]       o_flags,
    input  logic             i_clr_err,
    output logic [CNT_W-1:0] o_err_count
);

    logic [BITS-1:0]  mem_result_q [2];
    logic [3:0]       mem_flags_q  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             push, pop;
    logic [BITS-1:0]  in_result;
    logic [3:0]       in_flags;

    // Handshake outputs come only from registered count, never from the opposite side's inputs.
    assign o_ready     = (count_q != 2'd2);
    assign o_valid     = (count_q != 2'd0);
    assign push        = i_valid & o_ready;
    assign pop         = o_valid & i_ready;
    assign o_result    = o_valid ? mem_result_q[rd_ptr_q] : '0;
    assign o_flags     = o_valid ? mem_flags_q[rd_ptr_q]  : 4'b0000;
    assign o_err_count = err_cnt_q;

    // An errored beat's result is undefined, so store a clean zero instead of whatever arrived.
    always_comb begin
        in_result = '0;
        in_flags  = 4'b1000;
        if (!i_error) begin
            in_result = i_result;
            in_flags  = {1'b0, i_result[BITS-1], (i_result == '0), (i_result == '1)};
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        err_cnt_d = err_cnt_q;
        if (i_clr_err) begin
            err_cnt_d = '0;
        end else if (push && i_error && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_result_q[i] <= '0;
                mem_flags_q[i]  <= 4'b0000;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            if (push) begin
                mem_result_q[wr_ptr_q] <= in_result;
                mem_flags_q[wr_ptr_q]  <= in_flags;
            end
        end
    end

endmodule

// File: tb/tb_result_output_stage.sv
// tb/tb_result_output_stage.sv - directed self-checking bench for result_output_stage
module tb_result_output_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_ready;
    logic        clr_err;

    logic        out_ready, out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [7:0]  err_count;

    logic        s_ready, s_valid;
    logic [31:0] s_result;
    logic [3:0]  s_flags;
    logic [1:0]  s_err_count;

    int passed = 0;
    int total  = 0;

    result_output_stage #(.BITS(32), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(out_ready),
        .i_result(in_result), .i_error(in_error), .o_valid(out_valid), .i_ready(in_ready),
        .o_result(out_result), .o_flags(out_flags), .i_clr_err(clr_err), .o_err_count(err_count)
    );

    // Narrow counter instance so saturation is reachable in a few beats.
    result_output_stage #(.BITS(32), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(s_ready),
        .i_result(in_result), .i_error(in_error), .o_valid(s_valid), .i_ready(in_ready),
        .o_result(s_result), .o_flags(s_flags), .i_clr_err(clr_err), .o_err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_error = 1'b0;
        in_ready = 1'b0; clr_err = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_result !== 32'h0) $display("FAIL rst_result: got %h expected 0", out_result); else passed++;
        total++; if (out_flags !== 4'b0000) $display("FAIL rst_flags: got %b expected 0000", out_flags); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL rst_errcnt: got %0d expected 0", err_count); else passed++;
        total++; if (out_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", out_ready); else passed++;
    endtask

    task automatic test_single_beat();
        in_ready = 1'b1; in_valid = 1'b1; in_result = 32'h0000_0010; in_error = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL single_no_comb: got %b expected 0", out_valid); else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_result !== 32'h10) $display("FAIL single_result: got %h expected 00000010", out_result); else passed++;
        total++; if (out_flags !== 4'b0000) $display("FAIL single_flags: got %b expected 0000", out_flags); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        in_ready = 1'b0; in_error = 1'b0;
        in_valid = 1'b1; in_result = 32'hFFFF_FFFF;
        tick();
        total++; if (out_ready !== 1'b1) $display("FAIL bp_ready_after1: got %b expected 1", out_ready); else passed++;
        in_result = 32'h0;
        tick();
        total++; if (out_ready !== 1'b0) $display("FAIL bp_ready_after2: got %b expected 0", out_ready); else passed++;
        in_result = 32'h5;
        tick();
        total++; if (out_ready !== 1'b0) $display("FAIL bp_held_ready: got %b expected 0", out_ready); else passed++;
        total++; if (out_result !== 32'hFFFF_FFFF) $display("FAIL bp_head_stable: got %h expected ffffffff", out_result); else passed++;
        total++; if (out_flags !== 4'b0101) $display("FAIL bp_flags_m1: got %b expected 0101", out_flags); else passed++;
        in_ready = 1'b1;
        tick();
        total++; if (out_result !== 32'h0) $display("FAIL bp_result_0: got %h expected 00000000", out_result); else passed++;
        total++; if (out_flags !== 4'b0010) $display("FAIL bp_flags_0: got %b expected 0010", out_flags); else passed++;
        total++; if (out_ready !== 1'b1) $display("FAIL bp_ready_reopen: got %b expected 1", out_ready); else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (out_result !== 32'h5) $display("FAIL bp_result_5: got %h expected 00000005", out_result); else passed++;
        total++; if (out_flags !== 4'b0000) $display("FAIL bp_flags_5: got %b expected 0000", out_flags); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_empty_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_result !== 32'h0) $display("FAIL bp_empty_result: got %h expected 0", out_result); else passed++;
    endtask

    task automatic test_back_to_back();
        in_ready = 1'b1; in_error = 1'b0;
        in_valid = 1'b1; in_result = 32'd100;
        tick();
        for (int k = 1; k <= 20; k++) begin
            in_result = 32'd100 + 32'(k);
            #1;
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b expected 1", k, out_valid); else passed++;
            total++; if (out_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected 1", k, out_ready); else passed++;
            total++; if (out_result !== 32'd99 + 32'(k)) $display("FAIL b2b_data_%0d: got %0d expected %0d", k, out_result, 99 + k); else passed++;
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_result !== 32'd120) $display("FAIL b2b_last: got %0d expected 120", out_result); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_err_saturate();
        do_reset();
        in_ready = 1'b1; in_valid = 1'b1; in_error = 1'b1; in_result = 32'hDEAD_BEEF;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (s_err_count !== 2'((k < 3) ? k : 3)) $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, s_err_count, (k < 3) ? k : 3); else passed++;
            total++; if (err_count !== 8'(k)) $display("FAIL wide_cnt_%0d: got %0d expected %0d", k, err_count, k); else passed++;
            total++; if (s_result !== 32'h0) $display("FAIL err_result_%0d: got %h expected 0", k, s_result); else passed++;
            total++; if (s_flags !== 4'b1000) $display("FAIL err_flags_%0d: got %b expected 1000", k, s_flags); else passed++;
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; in_valid = 1'b0; in_error = 1'b0;
        total++; if (s_err_count !== 2'd0) $display("FAIL clr_wins_sat: got %0d expected 0", s_err_count); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL clr_wins_wide: got %0d expected 0", err_count); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        in_ready = 1'b0; in_valid = 1'b1; in_error = 1'b1; in_result = 32'h1;
        tick();
        in_error = 1'b0; in_result = 32'h7;
        tick();
        in_valid = 1'b0;
        total++; if (err_count !== 8'd1) $display("FAIL ar_pre_cnt: got %0d expected 1", err_count); else passed++;
        total++; if (out_ready !== 1'b0) $display("FAIL ar_pre_full: got %b expected 0", out_ready); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_result !== 32'h0) $display("FAIL ar_result: got %h expected 0", out_result); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL ar_errcnt: got %0d expected 0", err_count); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (out_ready !== 1'b1) $display("FAIL ar_ready_release: got %b expected 1", out_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL ar_valid_release: got %b expected 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_err_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
